// File: rtl/alu_ctrl_pkg.sv
// Shared widths, opcodes and helpers for the ALU sequencer and its register file.
package alu_ctrl_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_OP_WIDTH  = 4;
    localparam int DEF_RAM_WIDTH = 9;
    localparam int NUM_REGS      = 8;

    typedef logic [DEF_OP_WIDTH-1:0] opcode_t;

    localparam opcode_t OP_ADD   = 4'd0;
    localparam opcode_t OP_SUB   = 4'd1;
    localparam opcode_t OP_AND   = 4'd2;
    localparam opcode_t OP_OR    = 4'd3;
    localparam opcode_t OP_XOR   = 4'd4;
    localparam opcode_t OP_LOADI = 4'd5;
    localparam opcode_t OP_LOAD  = 4'd6;
    localparam opcode_t OP_STORE = 4'd7;
    localparam opcode_t OP_NOP   = 4'hF;

    // Codes above STORE, including NOP, are rejected when offered as instructions.
    function automatic logic is_legal_op(input opcode_t op);
        return op <= OP_STORE;
    endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// 8-entry register file: two combinational read ports, a debug read port, one write port.
module alu_ctrl_regfile
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [2:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [2:0]       raddr_a,
    input  logic [2:0]       raddr_b,
    input  logic [2:0]       dbg_sel,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] regs_q [NUM_REGS];

    // NOTE: this array is built from flops, not a RAM macro, so an async clear of every entry is legal here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a  = regs_q[raddr_a];
    assign rdata_b  = regs_q[raddr_b];
    assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/alu_ctrl.sv
// Single-issue sequencer: accepts one instruction, drives the registered ALU, writes back or touches RAM.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int OP_WIDTH  = DEF_OP_WIDTH,
    parameter int RAM_WIDTH = DEF_RAM_WIDTH
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 inst_valid,
    output logic                 inst_ready,
    input  logic [OP_WIDTH-1:0]  inst_op,
    input  logic [2:0]           inst_rd,
    input  logic [2:0]           inst_rs,
    input  logic [WIDTH-1:0]     inst_imm,
    output logic [OP_WIDTH-1:0]  alu_op,
    output logic [WIDTH-1:0]     alu_l,
    output logic [WIDTH-1:0]     alu_r,
    input  logic [WIDTH-1:0]     alu_o,
    input  logic [RAM_WIDTH-1:0] alu_a,
    output logic                 ram_we,
    output logic [RAM_WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0]     ram_wdata,
    input  logic [WIDTH-1:0]     ram_rdata,
    output logic                 done,
    output logic                 err,
    input  logic [2:0]           dbg_sel,
    output logic [WIDTH-1:0]     dbg_data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EXEC = 3'd1;
    localparam logic [2:0] S_WB   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_ILL  = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [OP_WIDTH-1:0] op_q, alu_op_q;
    logic [2:0]          rd_q;
    logic [WIDTH-1:0]    alu_l_q, alu_r_q;
    logic [WIDTH-1:0]    issue_l, issue_r;
    logic [WIDTH-1:0]    rd_val, rs_val, rf_wdata;
    logic                done_q, done_d, err_q, err_d;
    logic                accept, legal, in_wb, rf_we;

    assign inst_ready = (state_q == S_IDLE);
    assign accept     = inst_valid & inst_ready;
    assign legal      = is_legal_op(inst_op);
    assign in_wb      = (state_q == S_WB);

    alu_ctrl_regfile #(.WIDTH(WIDTH)) u_regfile (
        .clk      (clk),
        .rst      (res),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (rf_wdata),
        .raddr_a  (inst_rd),
        .raddr_b  (inst_rs),
        .dbg_sel  (dbg_sel),
        .rdata_a  (rd_val),
        .rdata_b  (rs_val),
        .dbg_data (dbg_data)
    );

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = legal ? S_EXEC : S_ILL;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = (op_q == OP_LOAD) ? S_MEM : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue_l = rd_val;
        issue_r = rs_val;
        case (inst_op)
            OP_LOADI: begin issue_l = '0;     issue_r = inst_imm; end
            OP_LOAD:  begin issue_l = rs_val; issue_r = '0;       end
            default:  ;
        endcase
    end

    // LOAD retires from MEM with RAM data; STORE never writes a register.
    assign rf_we    = (in_wb && op_q != OP_LOAD && op_q != OP_STORE) || (state_q == S_MEM);
    assign rf_wdata = (state_q == S_MEM) ? ram_rdata : alu_o;
    assign done_d   = (in_wb && op_q != OP_LOAD) || (state_q == S_MEM) || (state_q == S_ILL);
    assign err_d    = (state_q == S_ILL);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NOP;
            rd_q     <= '0;
            alu_op_q <= OP_NOP;
            alu_l_q  <= '0;
            alu_r_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept) begin
                op_q <= inst_op;
                rd_q <= inst_rd;
            end
            if (accept && legal) begin
                alu_op_q <= inst_op;
                alu_l_q  <= issue_l;
                alu_r_q  <= issue_r;
            end else if (state_q == S_EXEC) begin
                alu_op_q <= OP_NOP;
            end
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_l     = alu_l_q;
    assign alu_r     = alu_r_q;
    assign ram_we    = in_wb && (op_q == OP_STORE);
    assign ram_addr  = alu_a;
    assign ram_wdata = alu_o;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl with a behavioural registered ALU and synchronous RAM.
module tb_alu_ctrl;
    import alu_ctrl_pkg::*;

    logic        clk, res;
    logic        inst_valid, inst_ready;
    logic [3:0]  inst_op;
    logic [2:0]  inst_rd, inst_rs;
    logic [15:0] inst_imm;
    logic [3:0]  alu_op;
    logic [15:0] alu_l, alu_r, alu_o;
    logic [8:0]  alu_a;
    logic        ram_we;
    logic [8:0]  ram_addr;
    logic [15:0] ram_wdata, ram_rdata;
    logic        done, err;
    logic [2:0]  dbg_sel;
    logic [15:0] dbg_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_ctrl #(.WIDTH(16), .OP_WIDTH(4), .RAM_WIDTH(9)) dut (
        .clk(clk), .res(res),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_op(inst_op),
        .inst_rd(inst_rd), .inst_rs(inst_rs), .inst_imm(inst_imm),
        .alu_op(alu_op), .alu_l(alu_l), .alu_r(alu_r), .alu_o(alu_o), .alu_a(alu_a),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .done(done), .err(err), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU; its reset is active-low, so it sees the inverted res.
    logic alu_rst_n;
    assign alu_rst_n = ~res;
    always @(posedge clk or negedge alu_rst_n) begin
        if (!alu_rst_n) begin
            alu_o <= '0;
            alu_a <= '0;
        end else begin
            case (alu_op)
                OP_ADD:   alu_o <= alu_l + alu_r;
                OP_SUB:   alu_o <= alu_l - alu_r;
                OP_AND:   alu_o <= alu_l & alu_r;
                OP_OR:    alu_o <= alu_l | alu_r;
                OP_XOR:   alu_o <= alu_l ^ alu_r;
                OP_LOADI: alu_o <= alu_r;
                OP_LOAD:  alu_a <= alu_l[8:0];
                OP_STORE: begin alu_a <= alu_l[8:0]; alu_o <= alu_r; end
                default:  ;
            endcase
        end
    end

    logic [15:0] ram_mem [512];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [15:0] imm;
        logic [2:0]  chk_reg;
        logic [15:0] exp_val;
        logic        exp_err;
        int          lat;
        logic [8:0]  exp_addr;
        logic [15:0] exp_wdata;
    } vec_t;

    vec_t vecs[17];
    vec_t exp_q[$];

    function automatic vec_t mk(logic [3:0] op, logic [2:0] rd, logic [2:0] rs, logic [15:0] imm,
                                logic [2:0] chk, logic [15:0] val, logic e, int lat,
                                logic [8:0] a, logic [15:0] wd);
        vec_t v;
        v.op = op; v.rd = rd; v.rs = rs; v.imm = imm; v.chk_reg = chk; v.exp_val = val;
        v.exp_err = e; v.lat = lat; v.exp_addr = a; v.exp_wdata = wd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_reset_outputs();
        check("rst_inst_ready", inst_ready, 1);
        check("rst_alu_op", alu_op, OP_NOP);
        check("rst_alu_l", alu_l, 0);
        check("rst_alu_r", alu_r, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            check("rst_dbg_data", dbg_data, 0);
        end
    endtask

    // Issue one vector; busy cycles carry a decoy instruction that must be ignored.
    task automatic run_vec(input vec_t v);
        int  k;
        bit  seen;
        vec_t got;
        k = 0;
        while (!inst_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_issue", inst_ready, 1);
        inst_valid = 1'b1; inst_op = v.op; inst_rd = v.rd; inst_rs = v.rs; inst_imm = v.imm;
        @(posedge clk);
        exp_q.push_back(v);
        seen = 0;
        for (k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            check("ram_we", ram_we, (v.op == OP_STORE && k == 2));
            if (k == 1) check("alu_op_exec", alu_op, (v.op <= OP_STORE) ? v.op : OP_NOP);
            else        check("alu_op_nop", alu_op, OP_NOP);
            if (v.op == OP_STORE && k == 2) begin
                check("store_addr", ram_addr, v.exp_addr);
                check("store_wdata", ram_wdata, v.exp_wdata);
            end
            if (done) begin
                seen = 1;
                inst_valid = 1'b0;
                got = exp_q.pop_front();
                check("latency", k - 1, got.lat);
                check("err", err, got.exp_err);
                dbg_sel = got.chk_reg;
                #1;
                check("reg_value", dbg_data, got.exp_val);
            end else begin
                check("ready_busy", inst_ready, 0);
                check("err_busy", err, 0);
                inst_valid = 1'b1; inst_op = OP_LOADI; inst_rd = v.chk_reg;
                inst_imm = 16'($urandom);
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            inst_valid = 1'b0;
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(OP_LOADI, 1, 0, 16'h1234, 1, 16'h1234, 0, 2, 0, 0);
        vecs[1]  = mk(OP_LOADI, 2, 0, 16'h0F0F, 2, 16'h0F0F, 0, 2, 0, 0);
        vecs[2]  = mk(OP_ADD,   1, 2, 16'h0,    1, 16'h2143, 0, 2, 0, 0);
        vecs[3]  = mk(OP_LOADI, 3, 0, 16'h0000, 3, 16'h0000, 0, 2, 0, 0);
        vecs[4]  = mk(OP_LOADI, 4, 0, 16'h0001, 4, 16'h0001, 0, 2, 0, 0);
        vecs[5]  = mk(OP_SUB,   3, 4, 16'h0,    3, 16'hFFFF, 0, 2, 0, 0);
        vecs[6]  = mk(OP_XOR,   3, 3, 16'h0,    3, 16'h0000, 0, 2, 0, 0);
        vecs[7]  = mk(OP_AND,   1, 2, 16'h0,    1, 16'h0103, 0, 2, 0, 0);
        vecs[8]  = mk(OP_OR,    4, 2, 16'h0,    4, 16'h0F0F, 0, 2, 0, 0);
        vecs[9]  = mk(OP_LOADI, 5, 0, 16'h0203, 5, 16'h0203, 0, 2, 0, 0);
        vecs[10] = mk(OP_LOADI, 6, 0, 16'hBEEF, 6, 16'hBEEF, 0, 2, 0, 0);
        vecs[11] = mk(OP_STORE, 5, 6, 16'h0,    5, 16'h0203, 0, 2, 9'h003, 16'hBEEF);
        vecs[12] = mk(OP_LOAD,  7, 5, 16'h0,    7, 16'hBEEF, 0, 3, 0, 0);
        vecs[13] = mk(4'hC,     1, 2, 16'h5555, 1, 16'h0103, 1, 1, 0, 0);
        vecs[14] = mk(OP_NOP,   2, 1, 16'hAAAA, 2, 16'h0F0F, 1, 1, 0, 0);
        vecs[15] = mk(OP_ADD,   0, 6, 16'h0,    0, 16'hBEEF, 0, 2, 0, 0);
        vecs[16] = mk(OP_ADD,   6, 6, 16'h0,    6, 16'h7DDE, 0, 2, 0, 0);

        res = 1'b1; inst_valid = 1'b0; inst_op = OP_NOP; inst_rd = 0; inst_rs = 0;
        inst_imm = 0; dbg_sel = 0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        res = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Mid-cycle reset with populated registers clears everything at once.
        @(negedge clk);
        #2 res = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        res = 1'b0;

        // Reset during EXEC discards the in-flight ADD.
        run_vec(mk(OP_LOADI, 2, 0, 16'h0005, 2, 16'h0005, 0, 2, 0, 0));
        inst_valid = 1'b1; inst_op = OP_ADD; inst_rd = 1; inst_rs = 2;
        @(posedge clk);
        @(negedge clk);
        inst_valid = 1'b0;
        check("abort_exec_op", alu_op, OP_ADD);
        #2 res = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        res = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        dbg_sel = 3'd1;
        #1 check("abort_r1", dbg_data, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
